// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, 8 sets x 128-bit lines
// Zero-wait hits in IDLE; a miss captures the line address and holds it through FILL.
module icache (
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_read,
  input  logic [15:0]  imem_address,
  output logic         imem_resp,
  output logic [15:0]  imem_rdata,
  output logic         pmem_read,
  output logic [15:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t       state, state_next;
  logic [7:0]   valid;
  logic [8:0]   tag_array  [8];
  logic [127:0] line_array [8];
  logic [15:0]  fill_address;

  logic [2:0]   offset;
  logic [2:0]   index;
  logic [8:0]   tag;
  logic         hit;
  logic         start_fill;
  logic         install;
  logic         unused_addr_lsb;

  assign offset          = imem_address[3:1];
  assign index           = imem_address[6:4];
  assign tag             = imem_address[15:7];
  assign unused_addr_lsb = imem_address[0];

  assign hit        = imem_read & valid[index] & (tag_array[index] == tag);
  assign start_fill = (state == IDLE) & imem_read & ~hit;
  assign install    = (state == FILL) & pmem_resp;
  assign imem_rdata = line_array[index][{offset, 4'b0000} +: 16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (imem_read && !hit) state_next = FILL;
      FILL:    if (pmem_resp)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_resp    = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = fill_address;
    case (state)
      IDLE:    imem_resp = hit;
      FILL:    pmem_read = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid        <= '0;
      fill_address <= '0;
    end else begin
      if (start_fill) fill_address <= {tag, index, 4'b0000};
      if (install)    valid[fill_address[6:4]] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_array[fill_address[6:4]]  <= fill_address[15:7];
      line_array[fill_address[6:4]] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a set/tag model
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_read;
  logic [15:0]  imem_address;
  logic         imem_resp;
  logic [15:0]  imem_rdata;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int errors = 0;
  int checks = 0;

  logic [127:0] pmem_mem [logic [15:0]];
  logic         ref_valid [8];
  logic [8:0]   ref_tag   [8];

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [15:0] k;
    k = {a[15:4], 4'b0000};
    if (!pmem_mem.exists(k)) pmem_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    return pmem_mem[k];
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [127:0] l;
    l = mem_line(a);
    return l[a[3:1]*16 +: 16];
  endfunction

  function automatic logic ref_hit(input logic [15:0] a);
    return ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[15:7]);
  endfunction

  function automatic void ref_install(input logic [15:0] a);
    ref_valid[a[6:4]] = 1'b1;
    ref_tag[a[6:4]]   = a[15:7];
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endfunction

  // Holds a request until served; the memory answers after dly waiting FILL cycles.
  task automatic do_fetch(input logic [15:0] a, input int dly, output int lat,
                          output logic [15:0] data, output logic [15:0] paddr, output int fills);
    int wait_n;
    @(negedge clk);
    imem_read = 1'b1;
    imem_address = a;
    pmem_resp = 1'b0;
    lat = 0;
    fills = 0;
    paddr = 16'h0000;
    wait_n = 0;
    #1;
    while (!imem_resp && lat < 60) begin
      if (pmem_read) begin
        paddr = pmem_address;
        if (wait_n == dly) begin
          pmem_resp = 1'b1;
          pmem_rdata = mem_line(pmem_address);
          fills++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      lat++;
    end
    data = imem_rdata;
    imem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_read = 1'b1;
    imem_address = 16'h1234;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    ref_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL reset_imem_resp: got %b expected 0", imem_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL reset_pmem_address: got %h expected 0000", pmem_address); end
    imem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [127:0] l;
    int lat, fills;
    logic [15:0] data, paddr;
    l = mem_line(16'h1230);
    l[47:32] = 16'hABCD;
    pmem_mem[16'h1230] = l;
    do_fetch(16'h1234, 3, lat, data, paddr, fills);
    ref_install(16'h1234);
    checks++; if (lat != 5) begin errors++; $display("FAIL cold_latency: got %0d expected 5", lat); end
    checks++; if (paddr !== 16'h1230) begin errors++; $display("FAIL cold_pmem_address: got %h expected 1230", paddr); end
    checks++; if (data !== 16'hABCD) begin errors++; $display("FAIL cold_rdata: got %h expected abcd", data); end
    checks++; if (fills != 1) begin errors++; $display("FAIL cold_fills: got %0d expected 1", fills); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    imem_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 16'h1230 + 16'(2 * i);
      imem_address = a;
      #1;
      checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL stream_resp[%0d]: got %b expected 1", i, imem_resp); end
      checks++; if (imem_rdata !== mem_word(a)) begin errors++; $display("FAIL stream_rdata[%0d]: got %h expected %h", i, imem_rdata, mem_word(a)); end
      checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL stream_pmem_read[%0d]: got %b expected 0", i, pmem_read); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (imem_resp !== 1'b1 || imem_rdata !== mem_word(16'h123E)) begin
        errors++; $display("FAIL hold_hit[%0d]: got resp=%b data=%h expected resp=1 data=%h", i, imem_resp, imem_rdata, mem_word(16'h123E));
      end
    end
    imem_read = 1'b0;
  endtask

  task automatic test_conflict();
    int lat, fills;
    logic [15:0] data, paddr;
    do_fetch(16'h5230, 2, lat, data, paddr, fills);
    ref_install(16'h5230);
    checks++; if (lat != 4) begin errors++; $display("FAIL conflict_latency: got %0d expected 4", lat); end
    checks++; if (paddr !== 16'h5230) begin errors++; $display("FAIL conflict_pmem_address: got %h expected 5230", paddr); end
    checks++; if (data !== mem_word(16'h5230)) begin errors++; $display("FAIL conflict_rdata: got %h expected %h", data, mem_word(16'h5230)); end
    do_fetch(16'h1230, 1, lat, data, paddr, fills);
    ref_install(16'h1230);
    checks++; if (lat != 3) begin errors++; $display("FAIL reconflict_latency: got %0d expected 3", lat); end
    checks++; if (data !== mem_word(16'h1230)) begin errors++; $display("FAIL reconflict_rdata: got %h expected %h", data, mem_word(16'h1230)); end
  endtask

  task automatic test_withdraw();
    int lat, fills;
    logic [15:0] data, paddr;
    @(negedge clk);
    imem_read = 1'b1;
    imem_address = 16'h0040;
    @(negedge clk);
    imem_read = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0040) begin
      errors++; $display("FAIL withdraw_fill: got read=%b addr=%h expected read=1 addr=0040", pmem_read, pmem_address);
    end
    // Set 3 holds 0x1230, but nothing may be served while the fill is outstanding.
    @(negedge clk);
    imem_read = 1'b1;
    imem_address = 16'h1230;
    #1;
    checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL fill_blocks_hit: got %b expected 0", imem_resp); end
    checks++; if (pmem_address !== 16'h0040) begin errors++; $display("FAIL fill_addr_stable: got %h expected 0040", pmem_address); end
    imem_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = mem_line(16'h0040);
    @(negedge clk);
    pmem_resp = 1'b0;
    ref_install(16'h0040);
    do_fetch(16'h0046, 0, lat, data, paddr, fills);
    checks++; if (lat != 0) begin errors++; $display("FAIL withdraw_hit_latency: got %0d expected 0", lat); end
    checks++; if (data !== mem_word(16'h0046)) begin errors++; $display("FAIL withdraw_rdata: got %h expected %h", data, mem_word(16'h0046)); end
  endtask

  task automatic test_reset_mid_fill();
    int lat, fills;
    logic [15:0] data, paddr;
    @(negedge clk);
    imem_read = 1'b1;
    imem_address = 16'h2000;
    @(negedge clk);
    #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL midfill_pmem_read: got %b expected 1", pmem_read); end
    rst = 1'b1;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL async_reset_pmem_read: got %b expected 0", pmem_read); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL async_reset_pmem_address: got %h expected 0000", pmem_address); end
    imem_read = 1'b0;
    ref_clear();
    @(negedge clk);
    rst = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = mem_line(16'h2000);
    @(negedge clk);
    pmem_resp = 1'b0;
    do_fetch(16'h2000, 1, lat, data, paddr, fills);
    ref_install(16'h2000);
    checks++; if (lat != 3) begin errors++; $display("FAIL post_reset_miss_latency: got %0d expected 3", lat); end
    checks++; if (data !== mem_word(16'h2000)) begin errors++; $display("FAIL post_reset_rdata: got %h expected %h", data, mem_word(16'h2000)); end
  endtask

  task automatic test_stray_response();
    int lat, fills;
    logic [15:0] data, paddr;
    @(negedge clk);
    imem_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {128{1'b1}};
    @(negedge clk);
    pmem_resp = 1'b0;
    do_fetch(16'h2002, 0, lat, data, paddr, fills);
    checks++; if (lat != 0) begin errors++; $display("FAIL stray_hit_latency: got %0d expected 0", lat); end
    checks++; if (data !== mem_word(16'h2002)) begin errors++; $display("FAIL stray_rdata: got %h expected %h", data, mem_word(16'h2002)); end
  endtask

  task automatic test_random();
    int lat, fills, dly, exp_lat;
    logic [15:0] a, data, paddr;
    logic h;
    for (int n = 0; n < 60; n++) begin
      a = {7'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 7)), 4'($urandom)};
      dly = $urandom_range(0, 4);
      h = ref_hit(a);
      exp_lat = h ? 0 : dly + 2;
      do_fetch(a, dly, lat, data, paddr, fills);
      if (!h) ref_install(a);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d] addr=%h: got %0d expected %0d", n, a, lat, exp_lat); end
      checks++; if (data !== mem_word(a)) begin errors++; $display("FAIL rand_rdata[%0d] addr=%h: got %h expected %h", n, a, data, mem_word(a)); end
      if (!h) begin
        checks++; if (paddr !== {a[15:4], 4'b0000}) begin errors++; $display("FAIL rand_pmem_address[%0d]: got %h expected %h", n, paddr, {a[15:4], 4'b0000}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_withdraw();
    test_reset_mid_fill();
    test_stray_response();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameters: none; geometry fixed at 8 sets, direct-mapped, 8 x 16-bit words per line (128-bit line), read-only.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_read  input  1  fetch request, level-sensitive, held until served or withdrawn.
REQ-005 imem_address  input  16  fetch byte address; bit 0 ignored.
REQ-006 imem_resp  output  1  request served this cycle; imem_rdata valid.
REQ-007 imem_rdata  output  16  instruction word.
REQ-008 pmem_read  output  1  line-fill request to physical memory.
REQ-009 pmem_address  output  16  line-aligned fill address, bits [3:0] = 0.
REQ-010 pmem_resp  input  1  fill data valid this cycle.
REQ-011 pmem_rdata  input  128  fill line; word n in bits [16n+15:16n].

Function
REQ-012 Address split: offset = imem_address[3:1], index = imem_address[6:4], tag = imem_address[15:7] (9 bits).
REQ-013 Storage: per set one valid bit, one 9-bit tag, one 128-bit line; valid bits cleared by reset, tags/data not reset.
REQ-014 hit = imem_read & valid[index] & (tag_array[index] == tag), evaluated combinationally.
REQ-015 FSM states: IDLE, FILL; reset state IDLE.
REQ-016 IDLE: imem_resp = hit, same cycle as request (zero-wait hit); pmem_read = 0.
REQ-017 IDLE -> FILL on imem_read & ~hit; fill address {tag, index, 4'b0000} captured on that edge.
REQ-018 FILL: pmem_read = 1, pmem_address = captured address, both stable until pmem_resp; imem_resp = 0.
REQ-019 FILL with pmem_resp = 1: pmem_rdata written to line[captured index], tag written, valid set, next state IDLE.
REQ-020 Request served in first IDLE cycle after fill via REQ-016; miss latency = (cycles to pmem_resp) + 2.
REQ-021 imem_rdata = word [offset] of line[index] at all times; meaningful only when imem_resp = 1.
REQ-022 imem_read held high with unchanged address on a hit: imem_resp = 1 every cycle (supports back-to-back fetch).
REQ-023 imem_read dropped or address changed during FILL: fill still completes and installs captured line; no abort.
REQ-024 pmem_resp while in IDLE: ignored, no array write.
REQ-025 Fill replaces valid line at same index unconditionally (no writeback; read-only).
REQ-026 Fill to index i with concurrent request in FILL: no imem_resp until return to IDLE, even if request would hit another set.

Reset
REQ-027 rst asserted: state -> IDLE, all valid bits -> 0, captured address -> 0, immediately and asynchronously.
REQ-028 Outputs during/after reset: imem_resp = 0 (all invalid), pmem_read = 0, pmem_address = 0x0000.
REQ-029 rst mid-FILL: pmem_read drops asynchronously; no line installed; later pmem_resp ignored (REQ-024).
REQ-030 First request after reset always misses.

Verification
REQ-031 Cold miss: reset, imem_read=1, addr 0x1234 -> next cycle pmem_read=1, pmem_address=0x1230; pmem_resp after 3 cycles with line word2=0xABCD -> following cycle imem_resp=1, imem_rdata=0xABCD.
REQ-032 Hit stream: after REQ-031, addresses 0x1230,0x1232,...,0x123E one per cycle -> imem_resp=1 every cycle, words 0..7 returned in order, pmem_read stays 0.
REQ-033 Conflict: fill 0x1230 then request 0x5230 (same index 3, different tag) -> miss, pmem_address=0x5230; then 0x1230 misses again.
REQ-034 Withdraw: miss on 0x0040, drop imem_read in FILL, pmem_resp arrives -> line installed; later 0x0046 hits with zero wait.
REQ-035 Reset mid-fill: miss on 0x2000, assert rst during FILL -> pmem_read=0 same cycle; pmem_resp then pulsed -> no install; 0x2000 misses again.
REQ-036 Stray response: pmem_resp=1 in IDLE with data 0xFFFF.. -> no array change, hits return prior data.
